// File: rtl/lcd_cmd_dispatcher_if.sv
// Handshake bundle between host, dispatcher and LCD_CTRL.
// slave = dispatcher view, master = environment (host + LCD_CTRL) view.
interface lcd_cmd_dispatcher_if;
  logic [3:0] in_cmd;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;

  modport master (output in_cmd, in_valid, busy, done,
                  input  in_ready, cmd, cmd_valid);
  modport slave  (input  in_cmd, in_valid, busy, done,
                  output in_ready, cmd, cmd_valid);
endinterface

// File: rtl/lcd_cmd_dispatcher.sv
// FIFO-buffered LCD command dispatcher; holds issue after a Write (code 0) until done.
// Optional CMD_FILTER_EN: codes 4'hC-4'hF are discarded at pop and flagged on sticky illegal.
module lcd_cmd_dispatcher #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  lcd_cmd_dispatcher_if.slave     bus,
  output logic [AW:0]             fifo_level,
  output logic [CNT_W-1:0]        issued_cnt,
  output logic                    seq_done,
  output logic                    illegal
);
  typedef enum logic {RUN, WAIT_DONE} state_t;

  localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      LVL_ONE  = 1;
  localparam logic [AW-1:0]    PTR_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  state_t        state, state_nxt;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          hold_vld;
  logic [3:0]    hold_cmd;
  logic [3:0]    head;
  logic          push, pop, load, xfer, head_bad, seq_clr;

  assign head          = mem[rd_ptr];
  assign xfer          = hold_vld && !bus.busy;
  assign bus.in_ready  = (fifo_level != FULL_LVL);
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.cmd       = hold_cmd;
  assign bus.cmd_valid = hold_vld;

`ifdef CMD_FILTER_EN
  assign head_bad = (head[3:2] == 2'b11);

  always_ff @(posedge clk or negedge reset)
    if (!reset)                illegal <= 1'b0;
    else if (pop && head_bad)  illegal <= 1'b1;
`else
  assign head_bad = 1'b0;
  assign illegal  = 1'b0;
`endif

  // A bad head is still popped; it just never reaches the holding register.
  assign load = pop && !head_bad;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    seq_clr   = 1'b0;
    case (state)
      RUN: begin
        if (xfer && hold_cmd == 4'h0)
          state_nxt = WAIT_DONE;
        else if (fifo_level != '0 && (!hold_vld || xfer))
          pop = 1'b1;
      end
      WAIT_DONE: begin
        if (bus.done) begin
          state_nxt = RUN;
          seq_clr   = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.in_cmd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      hold_vld   <= 1'b0;
      hold_cmd   <= 4'h0;
      issued_cnt <= '0;
      seq_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      seq_done <= seq_clr;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
      if (load) begin
        hold_vld <= 1'b1;
        hold_cmd <= head;
      end else if (xfer) begin
        hold_vld <= 1'b0;
      end
      // The seq_done clear outranks a same-edge transfer count.
      if (seq_clr)                         issued_cnt <= '0;
      else if (xfer && issued_cnt != '1)   issued_cnt <= issued_cnt + CNT_ONE;
    end
  end
endmodule
